// File: rtl/cic_region_sequencer_if.sv
// Handshake bundle between the CIC region sequencer and its neighbours.
// The slave side is the sequencer. The master side is the IGR, reset and CIC environment.
interface cic_region_sequencer_if;
    logic       CONSOLE_RESET_i;
    logic       FORCE_REGION_i;
    logic       FORCE_PAL_i;
    logic       CIC_FAIL_i;
    logic       PAL_o;
    logic       CIC_START_o;
    logic       SYS_RESET_o;
    logic       LOCKED_o;
    logic       GIVEUP_o;
    logic [2:0] RETRY_CNT_o;

    modport master (
        output CONSOLE_RESET_i,
        output FORCE_REGION_i,
        output FORCE_PAL_i,
        output CIC_FAIL_i,
        input  PAL_o,
        input  CIC_START_o,
        input  SYS_RESET_o,
        input  LOCKED_o,
        input  GIVEUP_o,
        input  RETRY_CNT_o
    );

    modport slave (
        input  CONSOLE_RESET_i,
        input  FORCE_REGION_i,
        input  FORCE_PAL_i,
        input  CIC_FAIL_i,
        output PAL_o,
        output CIC_START_o,
        output SYS_RESET_o,
        output LOCKED_o,
        output GIVEUP_o,
        output RETRY_CNT_o
    );
endinterface

// File: rtl/cic_region_sequencer.sv
// Sequences the CIC lock and the console reset on MCLKO.
// If the CIC lock fails, the sequencer flips the region and retries.
module cic_region_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 32767,
    parameter int unsigned PROBE_CYCLES  = 65535,
    parameter int unsigned FAIL_DEBOUNCE = 16,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input logic                  CLK_i,
    input logic                  NRST_i,
    cic_region_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PROBE,
        S_LOCKED,
        S_FAIL,
        S_HALT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PROBE_LAST  = 16'(PROBE_CYCLES - 1);
    localparam logic [7:0]  DBC_LIMIT   = 8'(FAIL_DEBOUNCE);
    localparam logic [2:0]  RETRY_MAX   = 3'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [7:0]  dbc;
    logic [7:0]  dbc_nxt;
    logic        pal;
    logic        pal_nxt;
    logic [2:0]  retry;
    logic [2:0]  retry_nxt;
    logic        restart;
    logic        watch;
    logic        fail_now;
    logic        start_q;
    logic        sysrst_q;
    logic        locked_q;
    logic        giveup_q;

    always_comb begin
        watch   = (state == S_PROBE) || (state == S_LOCKED);
        dbc_nxt = 8'd0;
        if (watch && bus.CIC_FAIL_i) begin
            dbc_nxt = (dbc == 8'hFF) ? dbc : dbc + 8'd1;
        end
        fail_now = watch && bus.CIC_FAIL_i && (dbc_nxt >= DBC_LIMIT);
    end

    always_comb begin
        state_nxt = state;
        pal_nxt   = pal;
        retry_nxt = retry;
        restart   = 1'b0;
        if (bus.CONSOLE_RESET_i) begin
            state_nxt = S_IDLE;
            retry_nxt = 3'd0;
        end else if (bus.FORCE_REGION_i) begin
            state_nxt = S_SETTLE;
            pal_nxt   = bus.FORCE_PAL_i;
            retry_nxt = 3'd0;
            restart   = 1'b1;
        end else if (fail_now) begin
            state_nxt = S_FAIL;
        end else begin
            unique case (state)
                S_IDLE:   state_nxt = S_SETTLE;
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) state_nxt = S_PROBE;
                end
                S_PROBE: begin
                    if (cnt == PROBE_LAST) state_nxt = S_LOCKED;
                end
                S_LOCKED: state_nxt = S_LOCKED;
                S_FAIL: begin
                    if (retry == RETRY_MAX) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_SETTLE;
                        pal_nxt   = ~pal;
                        retry_nxt = retry + 3'd1;
                    end
                end
                S_HALT:   state_nxt = S_HALT;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // One phase counter: it restarts on every state entry and on a force.
    always_comb begin
        cnt_nxt = 16'd0;
        if (!restart && (state_nxt == state) &&
            ((state == S_SETTLE) || (state == S_PROBE))) begin
            cnt_nxt = cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            dbc      <= 8'd0;
            pal      <= 1'b0;
            retry    <= 3'd0;
            start_q  <= 1'b0;
            sysrst_q <= 1'b1;
            locked_q <= 1'b0;
            giveup_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dbc      <= dbc_nxt;
            pal      <= pal_nxt;
            retry    <= retry_nxt;
            start_q  <= (state == S_PROBE) || (state == S_LOCKED);
            sysrst_q <= (state != S_LOCKED);
            locked_q <= (state == S_LOCKED);
            giveup_q <= (state == S_HALT);
        end
    end

    assign bus.PAL_o       = pal;
    assign bus.CIC_START_o = start_q;
    assign bus.SYS_RESET_o = sysrst_q;
    assign bus.LOCKED_o    = locked_q;
    assign bus.GIVEUP_o    = giveup_q;
    assign bus.RETRY_CNT_o = retry;

endmodule
